sram_access_pipe: RTL and testbench

- Parametrised successor to sram_manager. Accepts one pre-decoded load/store request per cycle and drives the sramc controller.
- Tracks in-flight loads through a tag pipeline of depth READ_LATENCY, so back-to-back loads retire on back-to-back cycles.
- Forwards data from recent stores that the SRAM cannot yet return.
- Produces a register-file writeback (integer or float file) exactly READ_LATENCY cycles after each load issues.

---
 rtl/sram_access_pipe_if.sv | 37 +++
 rtl/sram_access_pipe.sv | 90 +++++++++
 tb/tb_sram_access_pipe.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_pipe_if.sv
// Request, SRAM-controller and writeback signals of sram_access_pipe.
// The pipe itself connects through the slave modport.
interface sram_access_pipe_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5
);
    logic                  req_valid;
    logic                  req_write;
    logic                  req_float;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [REG_WIDTH-1:0]  req_dest;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_read;

    logic                  wb_enable;
    logic [REG_WIDTH-1:0]  wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_float;
    logic [3:0]            inflight;

    modport slave (
        input  req_valid, req_write, req_float, req_addr, req_wdata, req_dest, mem_read,
        output mem_address, mem_write, mem_write_enable,
        output wb_enable, wb_addr, wb_data, wb_float, inflight
    );

    modport master (
        output req_valid, req_write, req_float, req_addr, req_wdata, req_dest, mem_read,
        input  mem_address, mem_write, mem_write_enable,
        input  wb_enable, wb_addr, wb_data, wb_float, inflight
    );
endinterface

// File: rtl/sram_access_pipe.sv
// Load/store issue to sramc with a READ_LATENCY-deep tag pipeline and
// forwarding from stores the SRAM cannot yet return.
module sram_access_pipe #(
    parameter int unsigned ADDR_WIDTH    = 20,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_WIDTH     = 5,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned HAZARD_WINDOW = 2
) (
    input logic          clk,
    input logic          reset,
    sram_access_pipe_if.slave bus
);
    localparam int unsigned HistDepth = (HAZARD_WINDOW > 0) ? HAZARD_WINDOW : 1;
    localparam bit          HistEn    = (HAZARD_WINDOW > 0);

    typedef struct packed {
        logic                  valid;
        logic [REG_WIDTH-1:0]  dest;
        logic                  is_float;
        logic                  fwd_hit;
        logic [DATA_WIDTH-1:0] fwd_data;
    } stage_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } hist_t;

    stage_t                stage_q [READ_LATENCY];
    hist_t                 hist_q  [HistDepth];
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [3:0]            inflight_q, inflight_d;
    logic                  is_load, is_store, fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    stage_t                last;

    assign is_store = bus.req_valid & bus.req_write & reset;
    assign is_load  = bus.req_valid & ~bus.req_write & reset;
    assign last     = stage_q[READ_LATENCY-1];

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = int'(HistDepth) - 1; i >= 0; i--) begin
            if (i < int'(HAZARD_WINDOW) && hist_q[i].valid && hist_q[i].addr == bus.req_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = hist_q[i].data;
            end
        end
    end

    assign bus.mem_address      = bus.req_valid ? bus.req_addr : last_addr_q;
    assign bus.mem_write        = bus.req_wdata;
    assign bus.mem_write_enable = is_store;

    always_comb begin
        bus.wb_enable = last.valid;
        bus.wb_addr   = '0;
        bus.wb_float  = 1'b0;
        bus.wb_data   = '0;
        if (last.valid) begin
            bus.wb_addr  = last.dest;
            bus.wb_float = last.is_float;
            bus.wb_data  = last.fwd_hit ? last.fwd_data : bus.mem_read;
        end
    end

    assign inflight_d   = inflight_q + {3'b000, is_load} - {3'b000, last.valid};
    assign bus.inflight = inflight_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) stage_q[i] <= '0;
            for (int i = 0; i < int'(HistDepth); i++) hist_q[i] <= '0;
            last_addr_q <= '0;
            inflight_q  <= '0;
        end else begin
            stage_q[0] <= '{valid: is_load, dest: bus.req_dest, is_float: bus.req_float,
                            fwd_hit: fwd_hit, fwd_data: fwd_data};
            for (int i = 1; i < int'(READ_LATENCY); i++) stage_q[i] <= stage_q[i-1];
            hist_q[0] <= '{valid: HistEn & is_store, addr: bus.req_addr, data: bus.req_wdata};
            for (int i = 1; i < int'(HistDepth); i++) hist_q[i] <= hist_q[i-1];
            if (bus.req_valid) last_addr_q <= bus.req_addr;
            inflight_q <= inflight_d;
        end
    end
endmodule

// File: tb/tb_sram_access_pipe.sv
// Drives two pipes (RL=2/HW=2 and RL=3/HW=0) with shared stimulus and checks
// them every cycle against an architectural-memory reference model.
module tb_sram_access_pipe;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          s_valid = 1'b0, s_write = 1'b0, s_float = 1'b0;
    logic [AW-1:0] s_addr  = '0;
    logic [DW-1:0] s_wdata = '0;
    logic [RW-1:0] s_dest  = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    typedef struct {
        int            due;
        logic [RW-1:0] dest;
        logic          flt;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            when;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } pw_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Contents of a never-written SRAM word.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {12'hD00, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int unsigned RL = (g == 0) ? 2 : 3;
        localparam int unsigned HW = (g == 0) ? 2 : 0;

        sram_access_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW)) dif ();

        assign dif.req_valid = s_valid;
        assign dif.req_write = s_write;
        assign dif.req_float = s_float;
        assign dif.req_addr  = s_addr;
        assign dif.req_wdata = s_wdata;
        assign dif.req_dest  = s_dest;

        sram_access_pipe #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW),
            .READ_LATENCY(RL), .HAZARD_WINDOW(HW)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (dif)
        );

        // SRAM: reads return RL cycles later; writes become readable HW+1 cycles later.
        logic [DW-1:0] rd_pipe [RL];
        logic [DW-1:0] sram [logic [AW-1:0]];
        pw_t           pend [$];
        assign dif.mem_read = rd_pipe[RL-1];

        // Reference: every accepted store is immediately architecturally visible.
        logic [DW-1:0] arch [logic [AW-1:0]];
        exp_t          expq [$];
        logic [AW-1:0] last_addr = '0;
        int            cyc = 0;
        logic [DW-1:0] rd;
        exp_t          e;
        pw_t           pw;

        always @(posedge clk) begin
            rd = '0;
            if (!$isunknown(dif.mem_address))
                rd = sram.exists(dif.mem_address) ? sram[dif.mem_address]
                                                  : init_val(dif.mem_address);
            rd_pipe[0] <= rd;
            for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
            if (dif.mem_write_enable === 1'b1) begin
                pw.when = cyc + int'(HW);
                pw.a    = dif.mem_address;
                pw.d    = dif.mem_write;
                pend.push_back(pw);
            end
            while (pend.size() > 0 && pend[0].when <= cyc) begin
                sram[pend[0].a] = pend[0].d;
                void'(pend.pop_front());
            end

            while (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
            if (!reset) begin
                expq.delete();
                last_addr = '0;
            end else if (s_valid) begin
                last_addr = s_addr;
                if (s_write) begin
                    arch[s_addr] = s_wdata;
                end else begin
                    e.due  = cyc + int'(RL);
                    e.dest = s_dest;
                    e.flt  = s_float;
                    e.data = arch.exists(s_addr) ? arch[s_addr] : init_val(s_addr);
                    expq.push_back(e);
                end
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (started) begin
                bit due;
                due = (expq.size() > 0) && (expq[0].due == cyc);
                chk($sformatf("c%0d wb_enable", g), dif.wb_enable, due);
                chk($sformatf("c%0d wb_addr", g), dif.wb_addr, due ? expq[0].dest : '0);
                chk($sformatf("c%0d wb_float", g), dif.wb_float, due ? expq[0].flt : 1'b0);
                chk($sformatf("c%0d wb_data", g), dif.wb_data, due ? expq[0].data : '0);
                chk($sformatf("c%0d inflight", g), dif.inflight, 4'(expq.size()));
                chk($sformatf("c%0d mem_write_enable", g), dif.mem_write_enable,
                    s_valid & s_write & reset);
                chk($sformatf("c%0d mem_address", g), dif.mem_address,
                    s_valid ? s_addr : last_addr);
                chk($sformatf("c%0d mem_write", g), dif.mem_write, s_wdata);
            end
        end
    end

    task automatic step(input bit v, input bit w, input bit f, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [RW-1:0] dst);
        s_valid = v;
        s_write = w;
        s_float = f;
        s_addr  = a;
        s_wdata = d;
        s_dest  = dst;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, 1'b1, 1'b0, a, d, RW'($urandom));
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [RW-1:0] dst, input bit f);
        step(1'b1, 1'b0, f, a, DW'($urandom), dst);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), RW'($urandom));
    endtask

    // One reset-low cycle carrying a store that must not reach the SRAM.
    task automatic do_reset();
        s_valid = 1'b1;
        s_write = 1'b1;
        s_addr  = AW'($urandom);
        s_wdata = DW'($urandom);
        reset   = 1'b0;
        #1;
        chk("lit rst mem_write_enable", g_cfg[0].dif.mem_write_enable, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic lit(input string name, input logic en, input logic [RW-1:0] a,
                       input logic [DW-1:0] d, input logic f);
        chk({"lit ", name, " en"}, g_cfg[0].dif.wb_enable, en);
        chk({"lit ", name, " addr"}, g_cfg[0].dif.wb_addr, a);
        chk({"lit ", name, " data"}, g_cfg[0].dif.wb_data, d);
        chk({"lit ", name, " float"}, g_cfg[0].dif.wb_float, f);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        started = 1'b1;
        idle(2);

        st(20'd15, 32'd10); idle(1); ld(20'd15, 5'd2, 1'b0); idle(1);
        lit("int fwd", 1'b1, 5'd2, 32'd10, 1'b0);

        st(20'd15, 32'd30); idle(1); ld(20'd15, 5'd2, 1'b1); idle(1);
        lit("float fwd", 1'b1, 5'd2, 32'd30, 1'b1);

        st(20'd20, 32'd9); st(20'd21, 32'd10); ld(20'd20, 5'd4, 1'b0); ld(20'd21, 5'd5, 1'b0);
        lit("b2b first", 1'b1, 5'd4, 32'd9, 1'b0);
        chk("lit b2b inflight", g_cfg[0].dif.inflight, 4'd2);
        idle(1);
        lit("b2b second", 1'b1, 5'd5, 32'd10, 1'b0);

        st(20'd40, 32'd5); ld(20'd40, 5'd6, 1'b0); idle(1);
        lit("adjacent fwd", 1'b1, 5'd6, 32'd5, 1'b0);
        st(20'd40, 32'd6); st(20'd40, 32'd7); ld(20'd40, 5'd7, 1'b0); idle(1);
        lit("youngest wins", 1'b1, 5'd7, 32'd7, 1'b0);

        st(20'd50, 32'd3); idle(4); ld(20'd50, 5'd8, 1'b0); st(20'd50, 32'd8);
        lit("later store", 1'b1, 5'd8, 32'd3, 1'b0);

        ld(20'd60, 5'd9, 1'b0); idle(1);
        chk("lit rl3 early en", g_cfg[1].dif.wb_enable, 1'b0);
        idle(1);
        chk("lit rl3 en", g_cfg[1].dif.wb_enable, 1'b1);
        chk("lit rl3 addr", g_cfg[1].dif.wb_addr, 5'd9);
        chk("lit rl3 data", g_cfg[1].dif.wb_data, 32'hD000_003C);
        idle(2);

        ld(20'd70, 5'd3, 1'b0); do_reset();
        lit("reset drop", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("lit reset inflight", g_cfg[0].dif.inflight, 4'd0);
        idle(1);
        chk("lit reset rl3 en", g_cfg[1].dif.wb_enable, 1'b0);
        idle(3);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                idle(3);
            end else begin
                step($urandom_range(0, 99) < 85, 1'($urandom), 1'($urandom),
                     {1'($urandom), 15'd0, 4'($urandom)}, DW'($urandom), RW'($urandom));
            end
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
